matrix_reader: RTL and testbench

- Readback engine for the DE-DP14112 LED matrix: issues the HT1632-style READ command (ID 110 + 7-bit address) to one selected driver chip.
- Strobes RD_n and assembles the returned 4-bit RAM nibbles.
- Sits beside the matrix write controller on the same CS_n/WR_n/RD_n/DATA pins; the top level arbitrates by holding one block idle.
- Used for display-RAM verification and frame readback.

---
 rtl/matrix_pkg.sv | 6 +
 rtl/matrix_reader_strobe_timer.sv | 29 ++
 rtl/matrix_reader.sv | 153 +++++++++++++++
 tb/tb_matrix_reader.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared state encoding and command constants for the LED matrix readback engine
package matrix_pkg;
  typedef enum logic [2:0] {IDLE, CSEL, CMD, TURN, RDBIT, CSREL, DONE} state_t;
  localparam logic [2:0] CMD_READ = 3'b110;
  localparam int ADDR_W = 7;
endpackage

// File: rtl/matrix_reader_strobe_timer.sv
// strobe_timer: half-period countdown that wraps at zero and toggles a phase bit
module strobe_timer #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  output logic o_end,
  output logic o_phase
);
  localparam int CW = $clog2(HALF);
  logic [CW-1:0] r_cnt;
  logic r_phase;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt <= CW'(HALF - 1);
      r_phase <= 1'b0;
    end else if (i_load) begin
      r_cnt <= CW'(HALF - 1);
      r_phase <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt <= CW'(HALF - 1);
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  assign o_end = r_cnt == '0;
  assign o_phase = r_phase;
endmodule

// File: rtl/matrix_reader.sv
// matrix_reader: issues READ (110 + addr) to one driver chip and assembles the returned nibbles
module matrix_reader
  import matrix_pkg::*;
#(
  parameter int NCHIP = 4,
  parameter int HALF = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        chip,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              nib_valid,
  output logic [3:0]        nib,
  output logic [ADDR_W-1:0] nib_addr,
  output logic [NCHIP-1:0]  cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              data_o,
  output logic              data_oe,
  input  logic              data_i
);
  state_t r_state;
  logic [1:0] r_sync;
  logic [ADDR_W-1:0] r_addr, r_cnt, r_nib_addr;
  logic [9:0] r_sh;
  logic [3:0] r_bit, r_nib;
  logic [2:0] r_shift;
  logic [NCHIP-1:0] r_cs_n;
  logic r_busy, r_done, r_err, r_nib_valid, r_wr_n, r_rd_n, r_data_o, r_data_oe;
  logic w_end, w_phase, w_load, w_din;
  // The timer wraps by itself; only entries into multi-phase states need the phase cleared
  assign w_load = r_state == IDLE || r_state == DONE || (w_end && (r_state == CSEL || r_state == TURN));
  assign w_din = r_sync[1];
  strobe_timer #(.HALF(HALF)) u_timer (
    .clk(clk), .reset(reset), .i_load(w_load), .o_end(w_end), .o_phase(w_phase)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_sync <= '0;
      r_addr <= '0;
      r_cnt <= '0;
      r_sh <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_nib <= '0;
      r_nib_addr <= '0;
      r_cs_n <= '1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_nib_valid <= 1'b0;
      r_wr_n <= 1'b1;
      r_rd_n <= 1'b1;
      r_data_o <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], data_i};
      r_done <= 1'b0;
      r_nib_valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_busy <= 1'b1;
          r_err <= 1'b0;
          if (count == '0) begin
            r_state <= DONE;
            r_done <= 1'b1;
          end else if (int'(chip) >= NCHIP) begin
            r_state <= DONE;
            r_done <= 1'b1;
            r_err <= 1'b1;
          end else begin
            r_state <= CSEL;
            r_addr <= addr;
            r_cnt <= count;
            r_sh <= {CMD_READ, addr};
            r_cs_n <= ~(NCHIP'(1) << chip);
            r_data_oe <= 1'b1;
          end
        end
        CSEL: if (w_end) begin
          r_state <= CMD;
          r_wr_n <= 1'b0;
          r_data_o <= r_sh[9];
          r_sh <= {r_sh[8:0], 1'b0};
          r_bit <= '0;
        end
        CMD: if (w_end) begin
          if (!w_phase) r_wr_n <= 1'b1;
          else if (r_bit == 4'd9) begin
            r_state <= TURN;
            r_data_oe <= 1'b0;
            r_data_o <= 1'b0;
          end else begin
            r_bit <= r_bit + 1'b1;
            r_wr_n <= 1'b0;
            r_data_o <= r_sh[9];
            r_sh <= {r_sh[8:0], 1'b0};
          end
        end
        TURN: if (w_end) begin
          r_state <= RDBIT;
          r_rd_n <= 1'b0;
          r_bit <= '0;
        end
        RDBIT: if (w_end) begin
          if (!w_phase) r_rd_n <= 1'b1;
          else if (r_bit == 4'd3) begin
            r_nib_valid <= 1'b1;
            r_nib <= {w_din, r_shift};
            r_nib_addr <= r_addr;
            r_addr <= r_addr + 1'b1;
            r_cnt <= r_cnt - 1'b1;
            r_bit <= '0;
            if (r_cnt == 7'd1) begin
              r_state <= CSREL;
              r_cs_n <= '1;
            end else r_rd_n <= 1'b0;
          end else begin
            r_shift[r_bit[1:0]] <= w_din;
            r_bit <= r_bit + 1'b1;
            r_rd_n <= 1'b0;
          end
        end
        CSREL: if (w_end) begin
          r_state <= DONE;
          r_done <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
          r_err <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign busy = r_busy;
  assign done = r_done;
  assign err = r_err;
  assign nib_valid = r_nib_valid;
  assign nib = r_nib;
  assign nib_addr = r_nib_addr;
  assign cs_n = r_cs_n;
  assign wr_n = r_wr_n;
  assign rd_n = r_rd_n;
  assign data_o = r_data_o;
  assign data_oe = r_data_oe;
endmodule

// File: tb/tb_matrix_reader.sv
// tb_matrix_reader: randomized scoreboard bench with a pin-level chip model and a reference RAM image
module tb_matrix_reader;
  localparam int H = 3;
  logic clk = 0, reset = 0, start = 0, start3 = 0, data_i = 0;
  logic [1:0] chip = 0;
  logic [6:0] addr = 0, count = 0;
  logic busy, done, err, nib_valid, wr_n, rd_n, data_o, data_oe;
  logic [3:0] nib, cs_n;
  logic [6:0] nib_addr;
  logic busy3, done3, err3, nv3, wr3, rd3, do3, oe3;
  logic [3:0] nib3;
  logic [6:0] na3;
  logic [2:0] cs3_n;
  matrix_reader #(.NCHIP(4), .HALF(H)) u_dut (
    .clk(clk), .reset(reset), .start(start), .chip(chip), .addr(addr), .count(count),
    .busy(busy), .done(done), .err(err), .nib_valid(nib_valid), .nib(nib), .nib_addr(nib_addr),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
  );
  matrix_reader #(.NCHIP(3), .HALF(H)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .chip(chip), .addr(addr), .count(count),
    .busy(busy3), .done(done3), .err(err3), .nib_valid(nv3), .nib(nib3), .nib_addr(na3),
    .cs_n(cs3_n), .wr_n(wr3), .rd_n(rd3), .data_o(do3), .data_oe(oe3), .data_i(1'b0)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, ndone = 0, bcnt = 0;
  logic [3:0] mem [4][128];
  logic [10:0] exp_nib [$];
  int exp_done [$];
  logic [3:0] exp_cs = '1;
  logic [9:0] exp_cmd = '0;
  bit quiet = 0;
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask
  // Chip model: decodes the command on WR_n rising edges, shifts out RAM bits D0-first on RD_n falling edges
  int nbits = 0, rbit = 0;
  logic [9:0] cmd = '0;
  logic [6:0] caddr = '0;
  always @(posedge wr_n)
    if (reset && cs_n != 4'hF) begin
      cmd = {cmd[8:0], data_o};
      nbits++;
      if (nbits == 10) begin
        caddr = cmd[6:0];
        check("cmd_bits", int'(cmd), int'(exp_cmd));
      end
    end
  always @(negedge rd_n) begin
    int a;
    a = 0;
    for (int i = 0; i < 4; i++) if (!cs_n[i]) a = i;
    data_i = mem[a][caddr][rbit];
    rbit++;
    if (rbit == 4) begin
      rbit = 0;
      caddr++;
    end
  end
  always @(cs_n) if (cs_n == 4'hF) begin
    nbits = 0;
    rbit = 0;
  end
  logic [10:0] e;
  int d;
  always @(negedge clk) if (reset) begin
    if (busy) bcnt++;
    if (nib_valid) begin
      if (exp_nib.size() == 0) check("nib_extra", 1, 0);
      else begin
        e = exp_nib.pop_front();
        check("nib_addr", int'(nib_addr), int'(e[10:4]));
        check("nib", int'(nib), int'(e[3:0]));
      end
    end
    if (done) begin
      ndone++;
      if (exp_done.size() == 0) check("done_extra", 1, 0);
      else begin
        d = exp_done.pop_front();
        check("latency", bcnt, d >> 1);
        check("err", int'(err), d & 1);
      end
      bcnt = 0;
    end
    checks++;
    if ((!wr_n && !rd_n) || (!rd_n && data_oe) || (cs_n != 4'hF && cs_n !== exp_cs) ||
        (quiet && (cs_n != 4'hF || !wr_n || !rd_n))) begin
      errors++;
      $display("FAIL pins cs_n=%b wr_n=%b rd_n=%b oe=%b required cs_n=%b or all-ones", cs_n, wr_n, rd_n, data_oe, exp_cs);
    end
  end
  task automatic run(input logic [1:0] c, input logic [6:0] a, input logic [6:0] n, input bit mid);
    int nd0;
    logic [6:0] x;
    exp_cs = ~(4'b0001 << c);
    exp_cmd = {3'b110, a};
    for (int i = 0; i < int'(n); i++) begin
      x = a + 7'(i);
      exp_nib.push_back({x, mem[c][x]});
    end
    exp_done.push_back((n == 0 ? 1 : H * (23 + 8 * int'(n)) + 1) * 2);
    quiet = (n == 0);
    nd0 = ndone;
    @(posedge clk) #1;
    chip = c; addr = a; count = n; start = 1;
    @(posedge clk) #1 start = 0;
    if (mid) begin
      for (int i = 0; i < 500 && rd_n; i++) @(posedge clk) #1;
      chip = 2'($urandom); addr = 7'($urandom); count = 5; start = 1;
      @(posedge clk) #1 start = 0;
    end
    for (int i = 0; i < 3000 && ndone == nd0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    check("done_count", ndone - nd0, 1);
    quiet = 0;
  endtask
  initial begin
    int seen, e3, act3;
    for (int c = 0; c < 4; c++) for (int a = 0; a < 128; a++) mem[c][a] = 4'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", int'(cs_n), 15);
    check("rst_wr_n", int'(wr_n), 1);
    check("rst_rd_n", int'(rd_n), 1);
    check("rst_data_o", int'(data_o), 0);
    check("rst_data_oe", int'(data_oe), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_nib", int'(nib), 0);
    check("rst_nib_addr", int'(nib_addr), 0);
    @(negedge clk) reset = 1;
    mem[1][5] = 4'b0101;
    run(2'd1, 7'h05, 7'd1, 0);
    mem[0][127] = 4'h1; mem[0][0] = 4'h2; mem[0][1] = 4'h3;
    run(2'd0, 7'h7F, 7'd3, 0);
    run(2'd2, 7'h10, 7'd0, 0);
    run(2'd3, 7'($urandom), 7'd2, 1);
    run(2'd3, 7'($urandom), 7'd1, 0);
    @(posedge clk) #1;
    chip = 2'd3; addr = 7'h20; count = 7'd2; start3 = 1;
    @(posedge clk) #1 start3 = 0;
    seen = 0; e3 = 0; act3 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done3) begin seen++; e3 = int'(err3); end
      if (cs3_n != 3'b111 || !wr3 || !rd3 || oe3) act3 = 1;
    end
    check("err3_done", seen, 1);
    check("err3_err", e3, 1);
    check("err3_pins", act3, 0);
    repeat (10) run(2'($urandom), 7'($urandom), 7'($urandom_range(0, 4)), 0);
    exp_cs = 4'b1011;
    exp_cmd = {3'b110, 7'h33};
    @(posedge clk) #1;
    chip = 2'd2; addr = 7'h33; count = 7'd2; start = 1;
    @(posedge clk) #1 start = 0;
    for (int i = 0; i < 500 && !(nbits == 4 && !wr_n); i++) @(negedge clk);
    check("reset_reach_bit4", nbits, 4);
    @(negedge clk) #2 reset = 0;
    #1;
    check("arst_cs_n", int'(cs_n), 15);
    check("arst_wr_n", int'(wr_n), 1);
    check("arst_rd_n", int'(rd_n), 1);
    check("arst_data_oe", int'(data_oe), 0);
    check("arst_busy", int'(busy), 0);
    exp_nib.delete();
    exp_done.delete();
    bcnt = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    run(2'd2, 7'($urandom), 7'd2, 0);
    check("nib_queue_empty", exp_nib.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout actual running required finished");
    $fatal(1);
  end
endmodule
